register_f_ctrl: RTL
====================

REGISTER_F_CTRL -- requirements
Module: register_f_ctrl

Interface
REQ-001 SHALL provide ports: Clk in 1, rising-edge clock; notReset in 1, asynchronous active-low reset.
REQ-002 SHALL provide FlagReq in 1: ALU requests a sign-flag update, held until FlagAck.
REQ-003 SHALL provide FlagSize in 2: 00 = bit7, 01 = bit15, 10 = CY8, 11 = illegal; stable while FlagReq high.
REQ-004 SHALL provide ExReq in 1: shadow-exchange request, held until ExAck.
REQ-005 SHALL provide WrReq in 1: direct flag-write request (load from ALUResult7), held until WrAck.
REQ-006 SHALL provide PF_Write_S out 1: flag-update enable to the flag register, active-high.
REQ-007 SHALL provide notPF_Select_S_bit7, notPF_Select_S_bit15 and notPF_Select_S_bit23 out 1 each: active-low source selects.
REQ-008 SHALL provide PR_Ex / notPR_Ex out 1 each, and PR_Write / notPR_Write out 1 each: complementary pairs, never equal.
REQ-009 SHALL provide FlagAck, ExAck and WrAck out 1 each: one-cycle grant pulses.
REQ-010 SHALL provide SizeErr out 1 (pulse), Busy out 1, and BankSel out 1 (current shadow bank).

Function
REQ-011 SHALL implement states IDLE, STROBE_F, STROBE_X, STROBE_W and GUARD; all outputs SHALL be registered, with no combinational path from requests to outputs.
REQ-012 SHALL arbitrate at each edge taken from IDLE, STROBE_F or STROBE_W: WrReq > ExReq > FlagReq, unless the starvation override (REQ-017) applies.
REQ-013 SHALL make the winner's STROBE state active for exactly one cycle, starting the cycle after the sampling edge (latency 1).
REQ-014 SHALL, in STROBE_F, drive PF_Write_S=1 and drive low only the select decoded from FlagSize; assert FlagAck.
- Illegal FlagSize: PF_Write_S=0, all selects high, FlagAck=1, SizeErr=1.
REQ-015 SHALL, in STROBE_X, drive PR_Ex=1 / notPR_Ex=0 and ExAck=1; toggle BankSel at the edge leaving STROBE_X; then enter GUARD for exactly one cycle, with no grant at that edge.
REQ-016 SHALL, in STROBE_W, drive PR_Write=1 / notPR_Write=0 and WrAck=1.
REQ-017 SHALL keep a 2-bit AgeCnt:
- increments when FlagReq=1 and another request is granted, saturating at 2;
- clears on a FlagReq grant or when FlagReq=0;
- AgeCnt==2 gives FlagReq top priority.
REQ-018 SHALL exclude, at the edge ending a STROBE state, the requester being acknowledged in that state; back-to-back grants go only to other requesters.
REQ-019 SHALL, when no request is eligible, return to IDLE, where all controls are inactive.
- Inactive = PF_Write_S=0, selects=1, PR_Ex=0, PR_Write=0, acks=0.
REQ-020 SHALL drive Busy=1 in every state except IDLE.
REQ-021 SHALL keep at most one of PF_Write_S, PR_Ex and PR_Write high in any cycle.

Reset
REQ-022 SHALL, on notReset low, immediately force:
- state IDLE, PF_Write_S=0, all three selects=1;
- PR_Ex=0, notPR_Ex=1, PR_Write=0, notPR_Write=1;
- all acks=0, SizeErr=0, Busy=0, BankSel=0, AgeCnt=0.
REQ-023 SHALL abort a reset asserted mid-STROBE with no ack completion; pending requests SHALL be arbitrated afresh at the first rising edge after release.

Verification
REQ-024 SHALL be covered by these directed scenarios:
- FlagReq=1, FlagSize=01 from IDLE -> next cycle PF_Write_S=1, notPF_Select_S_bit15=0, other selects 1, FlagAck=1; then IDLE.
- WrReq, ExReq and FlagReq rising together -> STROBE_W, STROBE_X, GUARD, STROBE_F in consecutive cycles; BankSel 0->1.
- FlagReq held while WrReq and ExReq re-request after each ack -> after two lost arbitrations FlagReq wins (AgeCnt==2) before the third competitor.
- FlagSize=11 -> FlagAck=1, SizeErr=1, PF_Write_S=0, all selects 1.
- Two ExReq handshakes -> BankSel 0->1->0, each STROBE_X followed by one GUARD cycle with Busy=1 and no ack.
- notReset low during STROBE_X -> PR_Ex=0 and ExAck=0 at once, BankSel=0; after release, held ExReq is granted 1 cycle after the first edge.

Source files
------------

// File: rtl/register_f_ctrl.sv
// Flag/shadow-register strobe controller: arbitrates ALU flag updates, shadow
// exchanges and direct flag writes into single-cycle registered strobes.
module register_f_ctrl (
  input  logic       Clk,
  input  logic       notReset,
  input  logic       FlagReq,
  input  logic [1:0] FlagSize,
  input  logic       ExReq,
  input  logic       WrReq,
  output logic       PF_Write_S,
  output logic       notPF_Select_S_bit7,
  output logic       notPF_Select_S_bit15,
  output logic       notPF_Select_S_bit23,
  output logic       PR_Ex,
  output logic       notPR_Ex,
  output logic       PR_Write,
  output logic       notPR_Write,
  output logic       FlagAck,
  output logic       ExAck,
  output logic       WrAck,
  output logic       SizeErr,
  output logic       Busy,
  output logic       BankSel
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_STROBE_F = 3'd1,
    ST_STROBE_X = 3'd2,
    ST_STROBE_W = 3'd3,
    ST_GUARD    = 3'd4
  } state_t;

  state_t     state_r;
  logic [1:0] age_cnt_r;
  logic [1:0] age_next_s;
  logic       flag_elig_s;
  logic       ex_elig_s;
  logic       wr_elig_s;
  logic       grant_f_s;
  logic       grant_x_s;
  logic       grant_w_s;

  // Active-low source selects {bit23, bit15, bit7}; an illegal size selects nothing.
  function automatic logic [2:0] sel_decode(input logic [1:0] size);
    logic [2:0] sel;
    case (size)
      2'b00:   sel = 3'b110;
      2'b01:   sel = 3'b101;
      2'b10:   sel = 3'b011;
      default: sel = 3'b111;
    endcase
    return sel;
  endfunction

  // Eligibility, priority arbitration and flag ageing for the coming edge.
  always_comb begin
    grant_f_s = 1'b0;
    grant_x_s = 1'b0;
    grant_w_s = 1'b0;
    // STROBE_X always moves to GUARD, so nothing is granted there; the requester
    // being acknowledged in the current strobe is excluded from the next grant.
    flag_elig_s = FlagReq && (state_r != ST_STROBE_X) && (state_r != ST_STROBE_F);
    ex_elig_s   = ExReq   && (state_r != ST_STROBE_X);
    wr_elig_s   = WrReq   && (state_r != ST_STROBE_X) && (state_r != ST_STROBE_W);
    if (flag_elig_s && (age_cnt_r == 2'd2)) begin
      grant_f_s = 1'b1;
    end else if (wr_elig_s) begin
      grant_w_s = 1'b1;
    end else if (ex_elig_s) begin
      grant_x_s = 1'b1;
    end else if (flag_elig_s) begin
      grant_f_s = 1'b1;
    end else begin
      grant_f_s = 1'b0;
    end
    // A flag request that is being acknowledged is not losing, so it does not age.
    if (!FlagReq || grant_f_s) begin
      age_next_s = 2'd0;
    end else if (flag_elig_s && (grant_w_s || grant_x_s) && (age_cnt_r != 2'd2)) begin
      age_next_s = age_cnt_r + 2'd1;
    end else begin
      age_next_s = age_cnt_r;
    end
  end

  // State register and registered strobe/ack outputs, cleared by async reset.
  always_ff @(posedge Clk or negedge notReset) begin
    if (!notReset) begin
      state_r              <= ST_IDLE;
      age_cnt_r            <= 2'd0;
      PF_Write_S           <= 1'b0;
      notPF_Select_S_bit7  <= 1'b1;
      notPF_Select_S_bit15 <= 1'b1;
      notPF_Select_S_bit23 <= 1'b1;
      PR_Ex                <= 1'b0;
      notPR_Ex             <= 1'b1;
      PR_Write             <= 1'b0;
      notPR_Write          <= 1'b1;
      FlagAck              <= 1'b0;
      ExAck                <= 1'b0;
      WrAck                <= 1'b0;
      SizeErr              <= 1'b0;
      Busy                 <= 1'b0;
      BankSel              <= 1'b0;
    end else begin
      PF_Write_S           <= 1'b0;
      notPF_Select_S_bit7  <= 1'b1;
      notPF_Select_S_bit15 <= 1'b1;
      notPF_Select_S_bit23 <= 1'b1;
      PR_Ex                <= 1'b0;
      notPR_Ex             <= 1'b1;
      PR_Write             <= 1'b0;
      notPR_Write          <= 1'b1;
      FlagAck              <= 1'b0;
      ExAck                <= 1'b0;
      WrAck                <= 1'b0;
      SizeErr              <= 1'b0;
      Busy                 <= 1'b1;
      age_cnt_r            <= age_next_s;
      if (state_r == ST_STROBE_X) begin
        state_r <= ST_GUARD;
        BankSel <= ~BankSel;
      end else if (grant_w_s) begin
        state_r     <= ST_STROBE_W;
        PR_Write    <= 1'b1;
        notPR_Write <= 1'b0;
        WrAck       <= 1'b1;
      end else if (grant_x_s) begin
        state_r  <= ST_STROBE_X;
        PR_Ex    <= 1'b1;
        notPR_Ex <= 1'b0;
        ExAck    <= 1'b1;
      end else if (grant_f_s) begin
        state_r <= ST_STROBE_F;
        {notPF_Select_S_bit23, notPF_Select_S_bit15, notPF_Select_S_bit7} <= sel_decode(FlagSize);
        PF_Write_S <= (FlagSize != 2'b11);
        SizeErr    <= (FlagSize == 2'b11);
        FlagAck    <= 1'b1;
      end else begin
        state_r <= ST_IDLE;
        Busy    <= 1'b0;
      end
    end
  end

endmodule
